pipe_ctrl: RTL

- Central pipeline sequencer for the 5-stage core.
- Decides each cycle whether PC and IF/ID hold, whether ID/EX takes a bubble or holds, whether EX/MEM takes a bubble, and whether the whole pipe flushes.
- Owns the multi-cycle divide wait, load-use interlock, and exception/ERET redirect.
- Drives the stall/flush inputs of id_ex and the neighbouring stage registers.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipe_ctrl_hazard.sv | 17 +
 rtl/pipe_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants and state encoding for the pipeline sequencer
package pipe_ctrl_pkg;
    localparam logic        FLUSH          = 1'b1;
    localparam logic        STALL          = 1'b1;
    localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
    localparam logic [31:0] EXC_ERET       = 32'h0000_000e;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DIV_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;
endpackage

// File: rtl/pipe_ctrl_hazard.sv
// hazard_detect: combinational load-use comparator between EX load and ID sources
module hazard_detect (
    input  logic       ex_is_load,
    input  logic [4:0] ex_w_dest,
    input  logic       id_reg1_read,
    input  logic [4:0] id_reg1_addr,
    input  logic       id_reg2_read,
    input  logic [4:0] id_reg2_addr,
    output logic       load_use
);
    // $zero is never a real dependency, so a load to it cannot stall
    always_comb begin
        load_use = ex_is_load && (ex_w_dest != 5'd0) &&
                   ((id_reg1_read && id_reg1_addr == ex_w_dest) ||
                    (id_reg2_read && id_reg2_addr == ex_w_dest));
    end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for divide wait, load-use interlock and exception redirect
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
    parameter int          DIV_TIMEOUT = 40,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_w_dest,
    input  logic             id_reg1_read,
    input  logic [4:0]       id_reg1_addr,
    input  logic             id_reg2_read,
    input  logic [4:0]       id_reg2_addr,
    input  logic             ex_div_start,
    input  logic             div_ready,
    input  logic [31:0]      mem_excepttype,
    input  logic [31:0]      cp0_epc,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_bubble,
    output logic             idex_hold,
    output logic             exmem_bubble,
    output logic             flush,
    output logic [31:0]      flush_pc,
    output logic             div_cancel,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int TW = $clog2(DIV_TIMEOUT + 1);

    state_t        state, state_nxt;
    logic [TW-1:0] timer;
    logic          exc, load_use, timeout;

    assign exc     = mem_excepttype != ZERO_WORD;
    assign timeout = timer >= TW'(DIV_TIMEOUT);

    hazard_detect u_hazard (
        .ex_is_load   (ex_is_load),
        .ex_w_dest    (ex_w_dest),
        .id_reg1_read (id_reg1_read),
        .id_reg1_addr (id_reg1_addr),
        .id_reg2_read (id_reg2_read),
        .id_reg2_addr (id_reg2_addr),
        .load_use     (load_use)
    );

    // state register; reset drops any in-flight divide without cancelling it
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_RUN;
        else      state <= state_nxt;
    end

    // divide timer counts DIV_WAIT cycles, starting at 1 on the issuing cycle
    always_ff @(posedge clk) begin
        if (!rst)                         timer <= '0;
        else if (state_nxt != ST_DIV_WAIT) timer <= '0;
        else                              timer <= (state == ST_DIV_WAIT) ? timer + 1'b1 : TW'(1);
    end

    // performance counter of stalled cycles, kept across flushes
    always_ff @(posedge clk) begin
        if (!rst)                  stall_cycles <= '0;
        else if (pc_hold && !flush) stall_cycles <= stall_cycles + 1'b1;
    end

    // next state: exception wins from any state, FLUSH lasts one cycle
    always_comb begin
        state_nxt = ST_RUN;
        if (exc)                         state_nxt = ST_FLUSH;
        else if (state == ST_RUN)        state_nxt = ex_div_start ? ST_DIV_WAIT : ST_RUN;
        else if (state == ST_DIV_WAIT)   state_nxt = (div_ready || timeout) ? ST_RUN : ST_DIV_WAIT;
    end

    // control outputs: exception > divide > load-use, all quiet during reset
    always_comb begin
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        idex_bubble  = 1'b0;
        idex_hold    = 1'b0;
        exmem_bubble = 1'b0;
        flush        = 1'b0;
        flush_pc     = ZERO_WORD;
        div_cancel   = 1'b0;
        if (rst) begin
            if (exc) begin
                flush      = FLUSH;
                flush_pc   = (mem_excepttype == EXC_ERET) ? cp0_epc : EXC_VECTOR;
                div_cancel = state == ST_DIV_WAIT;
            end else if ((state == ST_RUN && ex_div_start) ||
                         (state == ST_DIV_WAIT && !div_ready && !timeout)) begin
                pc_hold      = STALL;
                ifid_hold    = STALL;
                idex_hold    = STALL;
                exmem_bubble = STALL;
            end else if (state == ST_DIV_WAIT) begin
                div_cancel = !div_ready;
            end else if (state == ST_RUN && load_use) begin
                pc_hold     = STALL;
                ifid_hold   = STALL;
                idex_bubble = STALL;
            end
        end
    end
endmodule
